axi_store_unit: RTL and testbench

AXI_STORE_UNIT -- requirements
Module: axi_store_unit

---
 rtl/axi_store_unit_pkg.sv | 52 +++++
 rtl/axi_store_unit_store_align.sv | 21 ++
 rtl/axi_store_unit.sv | 211 +++++++++++++++++++++
 tb/tb_axi_store_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_store_unit_pkg.sv
// Shared types for the AXI store unit: FSM states, access-size encoding and
// the fixed single-beat AXI write attributes.
package axi_store_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_RESP   = 3'd3,
    ST_REJECT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEV  = 4'd0;
  localparam logic [2:0] AXI_PROT_NONE  = 3'd0;

  // Byte-lane mask of an access, before shifting to its lane offset.
  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [7:0] lanes;
    case (size)
      SIZE_B:  lanes = 8'h01;
      SIZE_H:  lanes = 8'h03;
      SIZE_W:  lanes = 8'h0F;
      SIZE_D:  lanes = 8'hFF;
      default: lanes = 8'h00;
    endcase
    return lanes;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_bits(input logic [1:0] size);
    logic [2:0] bits;
    case (size)
      SIZE_B:  bits = 3'b000;
      SIZE_H:  bits = 3'b001;
      SIZE_W:  bits = 3'b011;
      SIZE_D:  bits = 3'b111;
      default: bits = 3'b111;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/axi_store_unit_store_align.sv
// Places an LSB-justified store onto its 64-bit byte lanes and flags accesses
// that are not naturally aligned to their size.
module store_align
  import axi_store_unit_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic [63:0] data,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        misaligned
);

  // Lane placement and alignment test for one store.
  always_comb begin
    wdata      = data << {offset, 3'b000};
    wstrb      = size_lanes(size) << offset;
    misaligned = |(offset & size_align_bits(size));
  end

endmodule

// File: rtl/axi_store_unit.sv
// Single-outstanding AXI4 write master: turns one scalar store request into
// one single-beat write burst and reports completion with an error flag.
module axi_store_unit
  import axi_store_unit_pkg::*;
#(
  parameter int                  ID_WIDTH   = 13,
  parameter int                  ADDR_WIDTH = 64,
  parameter int                  DATA_WIDTH = 64,
  parameter logic [ID_WIDTH-1:0] WRITE_ID   = 13'h1
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [1:0]              req_size,

  output logic                    resp_valid,
  output logic                    resp_err,
  output logic                    busy,

  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  state_e                  state_r;
  state_e                  next_state_s;
  logic                    accept_s;
  logic                    b_err_s;

  logic [DATA_WIDTH-1:0]   align_wdata_s;
  logic [7:0]              align_wstrb_s;
  logic                    misaligned_s;

  logic                    awvalid_r;
  logic                    wvalid_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [7:0]              wstrb_r;

  logic                    req_ready_r;
  logic                    busy_r;
  logic                    bready_r;
  logic                    resp_valid_r;
  logic                    resp_err_r;

  store_align u_store_align (
    .offset     (req_addr[2:0]),
    .size       (req_size),
    .data       (req_data),
    .wdata      (align_wdata_s),
    .wstrb      (align_wstrb_s),
    .misaligned (misaligned_s)
  );

  // SLVERR/DECERR or a foreign ID both count as a failed write.
  assign b_err_s = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11) ||
                   (m_axi_bid != WRITE_ID);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode; SEND waits until both channel valids have retired.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (misaligned_s) begin
            next_state_s = ST_REJECT;
          end else begin
            next_state_s = ST_SEND;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!awvalid_r && !wvalid_r) begin
          next_state_s = ST_WAIT_B;
        end else begin
          next_state_s = ST_SEND;
        end
      end
      ST_WAIT_B: begin
        if (m_axi_bvalid) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT_B;
        end
      end
      ST_RESP:   next_state_s = ST_IDLE;
      ST_REJECT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      bready_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      req_ready_r  <= (next_state_s == ST_IDLE);
      busy_r       <= (next_state_s != ST_IDLE);
      bready_r     <= (next_state_s == ST_WAIT_B);
      resp_valid_r <= (next_state_s == ST_RESP) || (next_state_s == ST_REJECT);
      if (next_state_s == ST_REJECT) begin
        resp_err_r <= 1'b1;
      end else if (next_state_s == ST_RESP) begin
        resp_err_r <= b_err_s;
      end else begin
        resp_err_r <= 1'b0;
      end
    end
  end

  // AW/W valids: raised together on an aligned accept, each retired by its own handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
    end else if (accept_s && !misaligned_s) begin
      awvalid_r <= 1'b1;
      wvalid_r  <= 1'b1;
    end else begin
      if (awvalid_r && m_axi_awready) begin
        awvalid_r <= 1'b0;
      end else begin
        awvalid_r <= awvalid_r;
      end
      if (wvalid_r && m_axi_wready) begin
        wvalid_r <= 1'b0;
      end else begin
        wvalid_r <= wvalid_r;
      end
    end
  end

  // Payload captured only at accept, so later request changes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      awaddr_r <= '0;
      wdata_r  <= '0;
      wstrb_r  <= 8'h00;
    end else if (accept_s) begin
      awaddr_r <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
      wdata_r  <= align_wdata_s;
      wstrb_r  <= align_wstrb_s;
    end else begin
      awaddr_r <= awaddr_r;
      wdata_r  <= wdata_r;
      wstrb_r  <= wstrb_r;
    end
  end

  assign req_ready     = req_ready_r;
  assign busy          = busy_r;
  assign resp_valid    = resp_valid_r;
  assign resp_err      = resp_err_r;

  assign m_axi_awid    = WRITE_ID;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awlen   = AXI_LEN_SINGLE;
  assign m_axi_awsize  = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEV;
  assign m_axi_awprot  = AXI_PROT_NONE;
  assign m_axi_awvalid = awvalid_r;

  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_r;

  assign m_axi_bready  = bready_r;

endmodule

// File: tb/tb_axi_store_unit.sv
// Randomized self-checking bench for axi_store_unit against a transaction-level
// model of the store rules (lane placement, alignment, latency, error).
module tb_axi_store_unit;

  localparam logic [12:0] WID = 13'h1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic        resp_err;
  logic        busy;
  logic [12:0] m_axi_awid;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [12:0] m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  int n_checks = 0;
  int n_fail   = 0;

  axi_store_unit dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_size      (req_size),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .busy          (busy),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awlock  (m_axi_awlock),
    .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bid     (m_axi_bid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One store through the DUT with a scripted slave: awready from cycle 1+daw,
  // wready from 1+dw, bvalid db cycles after the write channel could retire.
  // Cycle 1 is the cycle after the accepting edge. After acceptance req_* are
  // replaced by the nxt_* values (held valid when nxt_valid=1).
  task automatic run_store(input string tag,
                           input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d,
                           input int daw, input int dw, input int db,
                           input logic [12:0] bid_v, input logic [1:0] bresp_v,
                           input logic nxt_valid, input logic [63:0] nxt_a,
                           input logic [1:0] nxt_sz, input logic [63:0] nxt_d,
                           output int waited);
    int          off, nbytes, exp_resp, aw_hs, w_hs, hs_done, resp_c;
    int          aw_cnt, w_cnt, br_cnt, busy_bad, rdy_bad;
    bit          mis, exp_err, b_taken, done, err_obs;
    logic [63:0] exp_awaddr, exp_wdata;
    logic [15:0] strb16;
    logic [7:0]  exp_wstrb;

    off        = int'(a % 64'd8);
    nbytes     = 1 << sz;
    mis        = (a % 64'(nbytes)) != 64'd0;
    exp_awaddr = a - 64'(off);
    exp_wdata  = d << (8 * off);
    strb16     = ((16'd1 << nbytes) - 16'd1) << off;
    exp_wstrb  = strb16[7:0];
    exp_err    = mis || bresp_v[1] || (bid_v != WID);
    exp_resp   = mis ? 1 : 4 + ((daw > dw) ? daw : dw) + db;

    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_data  = d;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, ".accept"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = nxt_valid;
    req_addr  = nxt_a;
    req_size  = nxt_sz;
    req_data  = nxt_d;

    aw_hs = -1; w_hs = -1; resp_c = -1; aw_cnt = 0; w_cnt = 0; br_cnt = 0;
    busy_bad = 0; rdy_bad = 0; b_taken = 1'b0; done = 1'b0; err_obs = 1'b0;
    for (int c = 1; c <= 80 && !done; c++) begin
      m_axi_awready = (c >= 1 + daw);
      m_axi_wready  = (c >= 1 + dw);
      hs_done = (aw_hs >= 0 && w_hs >= 0) ? ((aw_hs > w_hs) ? aw_hs : w_hs) : -1;
      if (c == 1) begin
        // stray response while no write is awaited: must be ignored
        m_axi_bvalid = 1'b1; m_axi_bid = WID; m_axi_bresp = 2'b10;
      end else if (hs_done >= 0 && c >= hs_done + 2 + db && !b_taken) begin
        m_axi_bvalid = 1'b1; m_axi_bid = bid_v; m_axi_bresp = bresp_v;
      end else begin
        m_axi_bvalid = 1'b0; m_axi_bid = 13'h0; m_axi_bresp = 2'b00;
      end
      if (resp_c >= 0) begin
        check_eq({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, ".idle_busy"}, 64'(busy), 64'd0);
        check_eq({tag, ".single_pulse"}, 64'(resp_valid), 64'd0);
        done = 1'b1;
      end else begin
        if (m_axi_awvalid) begin
          aw_cnt++;
          check_eq({tag, ".awaddr"}, m_axi_awaddr, exp_awaddr);
          check_eq({tag, ".awattr"}, 64'({m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                                          m_axi_awlock, m_axi_awcache, m_axi_awprot}),
                   64'({WID, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0}));
          if (m_axi_awready) aw_hs = c;
        end
        if (m_axi_wvalid) begin
          w_cnt++;
          check_eq({tag, ".wdata"}, m_axi_wdata, exp_wdata);
          check_eq({tag, ".wstrb_wlast"}, 64'({m_axi_wstrb, m_axi_wlast}), 64'({exp_wstrb, 1'b1}));
          if (m_axi_wready) w_hs = c;
        end
        if (m_axi_bready) br_cnt++;
        if (m_axi_bready && m_axi_bvalid) b_taken = 1'b1;
        if (!busy) busy_bad++;
        if (req_ready) rdy_bad++;
        if (resp_valid) begin
          resp_c  = c;
          err_obs = resp_err;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    check_eq({tag, ".resp_cycle"}, 64'(resp_c), 64'(exp_resp));
    check_eq({tag, ".resp_err"}, 64'(err_obs), 64'(exp_err));
    check_eq({tag, ".aw_cycles"}, 64'(aw_cnt), mis ? 64'd0 : 64'(1 + daw));
    check_eq({tag, ".w_cycles"}, 64'(w_cnt), mis ? 64'd0 : 64'(1 + dw));
    check_eq({tag, ".bready_cycles"}, 64'(br_cnt), mis ? 64'd0 : 64'(1 + db));
    check_eq({tag, ".busy_low_cycles"}, 64'(busy_bad), 64'd0);
    check_eq({tag, ".ready_high_cycles"}, 64'(rdy_bad), 64'd0);
  endtask

  initial begin
    int          w, cnt, pulses, leaks;
    logic [63:0] ca, cd, na, nd, amask;
    logic [1:0]  cs, ns;
    logic        b2b;

    reset = 1'b1;
    req_valid = 1'b0; req_addr = 64'd0; req_data = 64'd0; req_size = 2'd0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bid = 13'h0; m_axi_bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.outputs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, resp_valid, resp_err, busy}),
             64'd0);
    check_eq("reset.req_ready", 64'(req_ready), 64'd1);
    check_eq("reset.payload", m_axi_awaddr | m_axi_wdata, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_store("word_hi", 64'h1004, 2'd2, 64'hDEADBEEF, 0, 0, 0, WID, 2'b00,
              1'b0, 64'h1FFF, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, w);
    run_store("byte_awslow", 64'h2003, 2'd0, 64'hAB, 2, 0, 0, WID, 2'b00,
              1'b0, 64'h0, 2'd1, 64'h1234, w);
    run_store("misaligned", 64'h3002, 2'd2, 64'h11223344, 0, 0, 0, WID, 2'b00,
              1'b0, 64'h0, 2'd0, 64'h0, w);
    run_store("dword_slverr", 64'h5008, 2'd3, 64'h0123_4567_89AB_CDEF, 0, 0, 1, WID, 2'b10,
              1'b0, 64'h0, 2'd0, 64'h0, w);
    run_store("dword_badid", 64'h5010, 2'd3, 64'hCAFE_F00D_0000_0001, 1, 3, 0, 13'h5, 2'b00,
              1'b0, 64'h0, 2'd0, 64'h0, w);
    run_store("b2b_first", 64'h6000, 2'd3, 64'hA5A5_0000_1111_2222, 0, 1, 0, WID, 2'b00,
              1'b1, 64'h6012, 2'd1, 64'hBEEF, w);
    run_store("b2b_second", 64'h6012, 2'd1, 64'hBEEF, 0, 0, 0, WID, 2'b00,
              1'b0, 64'h0, 2'd0, 64'h0, w);
    check_eq("b2b.accept_wait", 64'(w), 64'd0);

    // reset while waiting for the write response
    req_valid = 1'b1; req_addr = 64'h7000; req_size = 2'd3; req_data = 64'h7777;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
    cnt = 0;
    while (!req_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt = 0;
    while (!m_axi_bready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check_eq("rst_mid.reach_wait_b", 64'(m_axi_bready), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_mid.bready", 64'(m_axi_bready), 64'd0);
    check_eq("rst_mid.busy", 64'(busy), 64'd0);
    check_eq("rst_mid.req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_mid.resp_valid", 64'(resp_valid), 64'd0);
    m_axi_bvalid = 1'b1; m_axi_bid = WID; m_axi_bresp = 2'b00;
    pulses = 0; leaks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
      if (m_axi_bready || busy) leaks++;
    end
    m_axi_bvalid = 1'b0;
    check_eq("rst_mid.no_resp", 64'(pulses), 64'd0);
    check_eq("rst_mid.stays_idle", 64'(leaks), 64'd0);

    // randomized traffic, some back-to-back with the next request held valid
    cs = 2'($urandom_range(3));
    ca = {$urandom(), $urandom()};
    cd = {$urandom(), $urandom()};
    if ($urandom_range(3) != 0) begin
      amask = ~((64'd1 << cs) - 64'd1);
      ca = ca & amask;
    end
    for (int i = 0; i < 40; i++) begin
      ns = 2'($urandom_range(3));
      na = {$urandom(), $urandom()};
      nd = {$urandom(), $urandom()};
      if ($urandom_range(3) != 0) begin
        amask = ~((64'd1 << ns) - 64'd1);
        na = na & amask;
      end
      b2b = ($urandom_range(1) == 1);
      run_store($sformatf("rnd%0d", i), ca, cs, cd,
                $urandom_range(3), $urandom_range(3), $urandom_range(3),
                ($urandom_range(9) == 0) ? 13'($urandom()) : WID, 2'($urandom_range(3)),
                b2b, na, ns, nd, w);
      ca = na; cs = ns; cd = nd;
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
